// File: rtl/mor_seq_pkg.sv
// Shared types for the Morse symbol sequencer: queued character format and FSM states.
package mor_seq_pkg;

  localparam int MOR_MAX_SYMS = 5;

  typedef struct packed {
    logic [2:0] len;
    logic [4:0] bits;
    logic       word_end;
  } mor_char_t;

  typedef enum logic [1:0] {IDLE, SYM, GAP, SPACE} seq_state_e;

endpackage

// File: rtl/mor_char_fifo.sv
// Small synchronous FIFO of encoded Morse characters with occupancy count.
module mor_char_fifo
  import mor_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  mor_char_t                wdata,
  input  logic                     pop,
  output mor_char_t                rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  mor_char_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mor_sym_sequencer.sv
// Pops queued Morse characters and serialises them into detector input pulses.
//   state | meaning
//   IDLE  | waiting for enable and a queued character; pops and classifies it
//   SYM   | emitting one dot/dash pulse for the current symbol
//   GAP   | silent inter-symbol cycles
//   SPACE | emitting the char- or word-space pulse that ends the character
module mor_sym_sequencer
  import mor_seq_pkg::*;
#(
  parameter int GAP_CYCLES = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_SYMS   = MOR_MAX_SYMS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_len,
  input  logic [4:0]                    in_bits,
  input  logic                          in_word_end,
  output logic                          dot_inp,
  output logic                          dash_inp,
  output logic                          char_space_inp,
  output logic                          word_space_inp,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          len_err
);

  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  seq_state_e  state_q, state_d;
  logic [4:0]  sym_bits_q, sym_bits_d;
  logic [2:0]  sym_cnt_q, sym_cnt_d;
  logic        word_end_q, word_end_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic        dot_d, dash_d, char_d, word_d, len_err_d;
  logic        push, pop, full, empty;
  logic [2:0]  align_sh;
  mor_char_t   head;
  mor_char_t   wr_char;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign wr_char  = '{len: in_len, bits: in_bits, word_end: in_word_end};
  assign busy     = (state_q != IDLE) || (fifo_count != '0);
  // Left-align the pattern so the first symbol always sits in bit 4.
  assign align_sh = 3'(MOR_MAX_SYMS) - head.len;

  mor_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_char),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d    = state_q;
    sym_bits_d = sym_bits_q;
    sym_cnt_d  = sym_cnt_q;
    word_end_d = word_end_q;
    gap_cnt_d  = gap_cnt_q;
    dot_d      = 1'b0;
    dash_d     = 1'b0;
    char_d     = 1'b0;
    word_d     = 1'b0;
    len_err_d  = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !empty) begin
          pop        = 1'b1;
          sym_bits_d = head.bits << align_sh;
          sym_cnt_d  = head.len;
          word_end_d = head.word_end;
          if (head.len > 3'(MAX_SYMS)) len_err_d = 1'b1;
          else if (head.len != 3'd0)   state_d   = SYM;
          else if (head.word_end)      state_d   = SPACE;
        end
      end
      SYM: begin
        dash_d     = sym_bits_q[4];
        dot_d      = !sym_bits_q[4];
        sym_bits_d = sym_bits_q << 1;
        sym_cnt_d  = sym_cnt_q - 3'd1;
        if (GAP_CYCLES > 0) begin
          state_d   = GAP;
          gap_cnt_d = GAP_LOAD;
        end else if (sym_cnt_q == 3'd1) begin
          state_d = SPACE;
        end
      end
      GAP: begin
        if (gap_cnt_q == 4'd0) state_d = (sym_cnt_q != 3'd0) ? SYM : SPACE;
        else                   gap_cnt_d = gap_cnt_q - 4'd1;
      end
      SPACE: begin
        word_d  = word_end_q;
        char_d  = !word_end_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      sym_bits_q     <= '0;
      sym_cnt_q      <= '0;
      word_end_q     <= 1'b0;
      gap_cnt_q      <= '0;
      dot_inp        <= 1'b0;
      dash_inp       <= 1'b0;
      char_space_inp <= 1'b0;
      word_space_inp <= 1'b0;
      len_err        <= 1'b0;
    end else begin
      state_q        <= state_d;
      sym_bits_q     <= sym_bits_d;
      sym_cnt_q      <= sym_cnt_d;
      word_end_q     <= word_end_d;
      gap_cnt_q      <= gap_cnt_d;
      dot_inp        <= dot_d;
      dash_inp       <= dash_d;
      char_space_inp <= char_d;
      word_space_inp <= word_d;
      len_err        <= len_err_d;
    end
  end

endmodule

// File: tb/tb_mor_sym_sequencer.sv
// Randomised bench for mor_sym_sequencer against a timeline model of the pulse stream.
module tb_mor_sym_sequencer;

  localparam int G = 1;

  typedef struct {
    int len;
    int bits;
    bit we;
  } ch_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_len = '0;
  logic [4:0] in_bits = '0;
  logic       in_word_end = 1'b0;
  logic       in_ready, dot_inp, dash_inp, char_space_inp, word_space_inp, busy, len_err;
  logic [2:0] fifo_count;

  int errors = 0;
  int checks = 0;
  int n = 0;
  int free_at = 0;
  int busy_end = 0;
  ch_t q[$];
  int exp_ev[int];

  mor_sym_sequencer #(.GAP_CYCLES(G), .FIFO_DEPTH(4), .MAX_SYMS(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_len         (in_len),
    .in_bits        (in_bits),
    .in_word_end    (in_word_end),
    .dot_inp        (dot_inp),
    .dash_inp       (dash_inp),
    .char_space_inp (char_space_inp),
    .word_space_inp (word_space_inp),
    .busy           (busy),
    .fifo_count     (fifo_count),
    .len_err        (len_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  // Event codes: 1 dot, 2 dash, 4 char space, 8 word space, 16 len_err.
  task automatic schedule(input ch_t c, input int t);
    int p;
    p = G + 1;
    if (c.len > 5) begin
      exp_ev[t] = 16;
      free_at = t + 1;
    end else if (c.len == 0) begin
      if (c.we) begin
        exp_ev[t+1] = 8;
        free_at = t + 2;
      end else begin
        free_at = t + 1;
      end
    end else begin
      for (int i = 0; i < c.len; i++)
        exp_ev[t+1+i*p] = (((c.bits >> (c.len-1-i)) & 1) != 0) ? 2 : 1;
      exp_ev[t+1+c.len*p] = c.we ? 8 : 4;
      free_at = t + 2 + c.len*p;
    end
    busy_end = free_at - 1;
  endtask

  task automatic cycle(input bit v, input int l, input int b, input bit we);
    ch_t c;
    bit acc;
    int ev;
    in_valid = v;
    in_len = 3'(l);
    in_bits = 5'(b);
    in_word_end = we;
    c.len = l;
    c.bits = b;
    c.we = we;
    acc = v && (q.size() != 4);
    @(posedge clk);
    n++;
    if (enable && q.size() > 0 && n >= free_at) schedule(q.pop_front(), n);
    if (acc) q.push_back(c);
    #1;
    ev = 0;
    if (exp_ev.exists(n)) begin
      ev = exp_ev[n];
      exp_ev.delete(n);
    end
    chk("pulses", {27'd0, len_err, word_space_inp, char_space_inp, dash_inp, dot_inp}, ev);
    chk("fifo_count", fifo_count, q.size());
    chk("in_ready", in_ready, (q.size() != 4));
    chk("busy", busy, ((n < busy_end) || (q.size() != 0)));
    in_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(0, 0, 0, 0);
  endtask

  initial begin
    #2;
    chk("rst_pulses", {dot_inp, dash_inp, char_space_inp, word_space_inp, len_err}, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    #1;
    chk("rst_ready", in_ready, 1);
    enable = 1'b1;
    idle(2);

    cycle(1, 1, 0, 0);              // E
    idle(8);
    cycle(1, 2, 5'b00001, 1);       // A, end of word
    idle(10);

    enable = 1'b0;
    for (int i = 0; i < 5; i++)
      cycle(1, $urandom_range(1, 5), $urandom_range(31), $urandom_range(1));
    idle(3);
    enable = 1'b1;
    idle(60);

    cycle(1, 7, 5'b10101, 0);
    cycle(1, 3, 5'b00110, 0);
    idle(12);
    cycle(1, 0, 0, 1);
    idle(4);
    cycle(1, 0, 0, 0);
    idle(4);

    for (int i = 0; i < 600; i++) begin
      int l;
      l = $urandom_range(9);
      if (l > 7) l = $urandom_range(1, 5);
      if ($urandom_range(15) == 0) enable = ~enable;
      cycle($urandom_range(1), l, $urandom_range(31), $urandom_range(1));
    end
    enable = 1'b1;
    idle(80);

    // Reset while a dash is on the wire with two characters still queued.
    cycle(1, 1, 1, 0);
    cycle(1, 3, 5, 0);
    cycle(1, 2, 2, 1);
    chk("dash_before_rst", dash_inp, 1);
    chk("queued_before_rst", fifo_count, 2);
    rst = 1'b0;
    #1;
    chk("async_rst_pulses", {dot_inp, dash_inp, char_space_inp, word_space_inp, len_err}, 0);
    chk("async_rst_count", fifo_count, 0);
    chk("async_rst_busy", busy, 0);
    q.delete();
    exp_ev.delete();
    free_at = 0;
    busy_end = 0;
    rst = 1'b1;
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
